// File: rtl/key_event_pkg.sv
// Shared state encoding and default timing constants for the key event decoder.
// Per-key FSMs and the top-level prescaler import this package.
package key_event_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHORT = 2'd1,
      HOLD  = 2'd2
   } key_state_t;

   localparam int unsigned DEF_CLK_FREQ  = 50_000_000;
   localparam int unsigned DEF_LONG_MS   = 1000;
   localparam int unsigned DEF_REPEAT_MS = 200;
   localparam int unsigned MS_CNT_W      = 16;

endpackage

// File: rtl/key_press_fsm.sv
// Per-key press classifier: short press, long press and auto-repeat pulses,
// all registered, driven by a shared millisecond tick.
module key_press_fsm
   import key_event_pkg::*;
#(
   parameter int unsigned LONG_MS   = DEF_LONG_MS,
   parameter int unsigned REPEAT_MS = DEF_REPEAT_MS
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic ms_tick,
   input  logic key_flag,
   input  logic key_bit,
   output logic short_press,
   output logic long_press,
   output logic repeat_press,
   output logic key_held
);

   localparam logic [MS_CNT_W-1:0] LONG_LAST   = MS_CNT_W'(LONG_MS - 1);
   localparam logic [MS_CNT_W-1:0] REPEAT_LAST = MS_CNT_W'(REPEAT_MS - 1);

   key_state_t          state, state_nxt;
   logic [MS_CNT_W-1:0] ms_cnt, ms_cnt_nxt;
   logic                short_nxt, long_nxt, repeat_nxt;
   logic                press_ev, release_ev;

   assign press_ev   = key_flag & ~key_bit;
   assign release_ev = key_flag & key_bit;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state        <= IDLE;
         ms_cnt       <= '0;
         short_press  <= 1'b0;
         long_press   <= 1'b0;
         repeat_press <= 1'b0;
         key_held     <= 1'b0;
      end else begin
         state        <= state_nxt;
         ms_cnt       <= ms_cnt_nxt;
         short_press  <= short_nxt;
         long_press   <= long_nxt;
         repeat_press <= repeat_nxt;
         key_held     <= (state_nxt != IDLE);
      end
   end

   // A release is checked before the tick so it wins when both land together.
   always_comb begin
      state_nxt  = state;
      ms_cnt_nxt = ms_cnt;
      case (state)
         IDLE: begin
            if (press_ev) begin
               state_nxt  = SHORT;
               ms_cnt_nxt = '0;
            end
         end
         SHORT: begin
            if (release_ev) begin
               state_nxt = IDLE;
            end else if (ms_tick) begin
               if (ms_cnt == LONG_LAST) begin
                  state_nxt  = HOLD;
                  ms_cnt_nxt = '0;
               end else begin
                  ms_cnt_nxt = ms_cnt + MS_CNT_W'(1);
               end
            end
         end
         HOLD: begin
            if (release_ev) begin
               state_nxt = IDLE;
            end else if (ms_tick) begin
               if (ms_cnt == REPEAT_LAST) begin
                  ms_cnt_nxt = '0;
               end else begin
                  ms_cnt_nxt = ms_cnt + MS_CNT_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      short_nxt  = (state == SHORT) && release_ev;
      long_nxt   = (state == SHORT) && !release_ev && ms_tick && (ms_cnt == LONG_LAST);
      repeat_nxt = (state == HOLD)  && !release_ev && ms_tick && (ms_cnt == REPEAT_LAST);
   end

endmodule

// File: rtl/key_event_decoder.sv
// Four-key event decoder: a shared millisecond prescaler feeding one
// key_press_fsm per key.
module key_event_decoder
   import key_event_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
   parameter int unsigned LONG_MS   = DEF_LONG_MS,
   parameter int unsigned REPEAT_MS = DEF_REPEAT_MS
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       key_flag,
   input  logic [3:0] key_value,
   output logic [3:0] short_press,
   output logic [3:0] long_press,
   output logic [3:0] repeat_press,
   output logic [3:0] key_held
);

   localparam int unsigned PRESC_MAX = CLK_FREQ / 1000 - 1;

   logic [31:0] presc_cnt;
   logic        ms_tick;

   assign ms_tick = (presc_cnt == PRESC_MAX);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         presc_cnt <= '0;
      end else if (ms_tick) begin
         presc_cnt <= '0;
      end else begin
         presc_cnt <= presc_cnt + 32'd1;
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_key
      key_press_fsm #(
         .LONG_MS   (LONG_MS),
         .REPEAT_MS (REPEAT_MS)
      ) u_fsm (
         .sys_clk      (sys_clk),
         .sys_rst_n    (sys_rst_n),
         .ms_tick      (ms_tick),
         .key_flag     (key_flag),
         .key_bit      (key_value[i]),
         .short_press  (short_press[i]),
         .long_press   (long_press[i]),
         .repeat_press (repeat_press[i]),
         .key_held     (key_held[i])
      );
   end

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: directed scenarios plus random flags, checked
// every cycle against a tick-counting reference model.
module tb_key_event_decoder;

   localparam int unsigned CLK_FREQ   = 1_000_000;
   localparam int unsigned LONG_MS    = 10;
   localparam int unsigned REPEAT_MS  = 4;
   localparam int unsigned CYC_PER_MS = CLK_FREQ / 1000;

   logic       sys_clk   = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       key_flag  = 1'b0;
   logic [3:0] key_value = 4'hF;
   logic [3:0] short_press, long_press, repeat_press, key_held;

   int checks   = 0;
   int failures = 0;

   always #5 sys_clk = ~sys_clk;

   key_event_decoder #(
      .CLK_FREQ  (CLK_FREQ),
      .LONG_MS   (LONG_MS),
      .REPEAT_MS (REPEAT_MS)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .key_flag     (key_flag),
      .key_value    (key_value),
      .short_press  (short_press),
      .long_press   (long_press),
      .repeat_press (repeat_press),
      .key_held     (key_held)
   );

   // Reference: each held key counts ms ticks since its press; the pulse kind
   // follows from that total alone.
   int unsigned m_cyc;
   bit          m_held [4];
   int unsigned m_ticks[4];
   logic [3:0]  e_s, e_l, e_r, e_h;

   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         m_cyc = 0;
         for (int i = 0; i < 4; i++) begin
            m_held[i]  = 0;
            m_ticks[i] = 0;
         end
         e_s = '0; e_l = '0; e_r = '0; e_h = '0;
      end else begin
         bit tick;
         tick  = (m_cyc % CYC_PER_MS) == CYC_PER_MS - 1;
         m_cyc = m_cyc + 1;
         e_s = '0; e_l = '0; e_r = '0;
         for (int i = 0; i < 4; i++) begin
            if (m_held[i]) begin
               if (key_flag && key_value[i]) begin
                  if (m_ticks[i] < LONG_MS) e_s[i] = 1'b1;
                  m_held[i] = 0;
               end else if (tick) begin
                  m_ticks[i] = m_ticks[i] + 1;
                  if (m_ticks[i] == LONG_MS) e_l[i] = 1'b1;
                  else if (m_ticks[i] > LONG_MS && (m_ticks[i] - LONG_MS) % REPEAT_MS == 0)
                     e_r[i] = 1'b1;
               end
            end else if (key_flag && !key_value[i]) begin
               m_held[i]  = 1;
               m_ticks[i] = 0;
            end
            e_h[i] = m_held[i];
         end
      end
   end

   task automatic test_reset();
      sys_rst_n = 1'b0;
      #2;
      checks++;
      if ({short_press, long_press, repeat_press, key_held} !== 16'h0000) begin
         failures++;
         $display("FAIL reset_async got=%h exp=0000", {short_press, long_press, repeat_press, key_held});
      end
      repeat (3) @(negedge sys_clk);
      checks++;
      if ({short_press, long_press, repeat_press, key_held} !== 16'h0000) begin
         failures++;
         $display("FAIL reset_clocked got=%h exp=0000", {short_press, long_press, repeat_press, key_held});
      end
      sys_rst_n = 1'b1;
   endtask

   task automatic test_short();
      int n_short = 0, n_long = 0, held_low = 0, first_idx = -1;
      key_value = 4'b1110; key_flag = 1'b1;
      for (int c = 0; c < 5 * CYC_PER_MS; c++) begin
         @(negedge sys_clk); key_flag = 1'b0;
         checks++;
         if ({short_press, long_press, repeat_press, key_held} !== {e_s, e_l, e_r, e_h}) begin
            failures++;
            $display("FAIL short_hold t=%0t got=%h exp=%h", $time, {short_press, long_press, repeat_press, key_held}, {e_s, e_l, e_r, e_h});
         end
         if (!key_held[0]) held_low++;
      end
      key_value = 4'b1111; key_flag = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge sys_clk); key_flag = 1'b0;
         checks++;
         if ({short_press, long_press, repeat_press, key_held} !== {e_s, e_l, e_r, e_h}) begin
            failures++;
            $display("FAIL short_release t=%0t got=%h exp=%h", $time, {short_press, long_press, repeat_press, key_held}, {e_s, e_l, e_r, e_h});
         end
         if (short_press == 4'b0001) begin n_short++; if (first_idx < 0) first_idx = c; end
         if (long_press != 4'b0000) n_long++;
      end
      checks++;
      if (n_short != 1 || first_idx != 0 || n_long != 0 || held_low != 0) begin
         failures++;
         $display("FAIL short_summary got short=%0d idx=%0d long=%0d held_low=%0d exp 1 0 0 0", n_short, first_idx, n_long, held_low);
      end
   endtask

   task automatic test_long();
      int n_long = 0, n_rep = 0, long_at = -1, n_rel = 0;
      key_value = 4'b1101; key_flag = 1'b1;
      for (int c = 0; c < 25 * CYC_PER_MS; c++) begin
         @(negedge sys_clk); key_flag = 1'b0;
         checks++;
         if ({short_press, long_press, repeat_press, key_held} !== {e_s, e_l, e_r, e_h}) begin
            failures++;
            $display("FAIL long_hold t=%0t got=%h exp=%h", $time, {short_press, long_press, repeat_press, key_held}, {e_s, e_l, e_r, e_h});
         end
         if (long_press == 4'b0010) begin n_long++; long_at = c; end
         if (repeat_press == 4'b0010) n_rep++;
      end
      key_value = 4'b1111; key_flag = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge sys_clk); key_flag = 1'b0;
         checks++;
         if ({short_press, long_press, repeat_press, key_held} !== {e_s, e_l, e_r, e_h}) begin
            failures++;
            $display("FAIL long_release t=%0t got=%h exp=%h", $time, {short_press, long_press, repeat_press, key_held}, {e_s, e_l, e_r, e_h});
         end
         if ((short_press | long_press | repeat_press) != 4'b0000) n_rel++;
      end
      checks++;
      if (n_long != 1 || n_rep != 3 || long_at < 9 * CYC_PER_MS - 1 || long_at > 10 * CYC_PER_MS || n_rel != 0) begin
         failures++;
         $display("FAIL long_summary got long=%0d at=%0d rep=%0d rel=%0d exp 1 ~10ms 3 0", n_long, long_at, n_rep, n_rel);
      end
   endtask

   task automatic test_coincide();
      int n_short = 0, n_long = 0;
      bit aligned = 0;
      key_value = 4'b1011; key_flag = 1'b1;
      for (int c = 0; c < 12 * CYC_PER_MS && !aligned; c++) begin
         @(negedge sys_clk); key_flag = 1'b0;
         checks++;
         if ({short_press, long_press, repeat_press, key_held} !== {e_s, e_l, e_r, e_h}) begin
            failures++;
            $display("FAIL coincide_hold t=%0t got=%h exp=%h", $time, {short_press, long_press, repeat_press, key_held}, {e_s, e_l, e_r, e_h});
         end
         if (m_ticks[2] == LONG_MS - 1 && (m_cyc % CYC_PER_MS) == CYC_PER_MS - 1) aligned = 1;
      end
      checks++;
      if (!aligned) begin
         failures++;
         $display("FAIL coincide_align got=not_found exp=10th_tick_within_12ms");
      end
      key_value = 4'b1111; key_flag = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge sys_clk); key_flag = 1'b0;
         checks++;
         if ({short_press, long_press, repeat_press, key_held} !== {e_s, e_l, e_r, e_h}) begin
            failures++;
            $display("FAIL coincide_release t=%0t got=%h exp=%h", $time, {short_press, long_press, repeat_press, key_held}, {e_s, e_l, e_r, e_h});
         end
         if (short_press == 4'b0100) n_short++;
         if (long_press != 4'b0000) n_long++;
      end
      checks++;
      if (n_short != 1 || n_long != 0) begin
         failures++;
         $display("FAIL coincide_summary got short=%0d long=%0d exp 1 0", n_short, n_long);
      end
   endtask

   task automatic test_dual();
      int n_pair = 0, n_any = 0;
      key_value = 4'b0110; key_flag = 1'b1;
      for (int c = 0; c < 3 * CYC_PER_MS; c++) begin
         @(negedge sys_clk); key_flag = 1'b0;
         checks++;
         if ({short_press, long_press, repeat_press, key_held} !== {e_s, e_l, e_r, e_h}) begin
            failures++;
            $display("FAIL dual_hold t=%0t got=%h exp=%h", $time, {short_press, long_press, repeat_press, key_held}, {e_s, e_l, e_r, e_h});
         end
      end
      key_value = 4'b1111; key_flag = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge sys_clk); key_flag = 1'b0;
         checks++;
         if ({short_press, long_press, repeat_press, key_held} !== {e_s, e_l, e_r, e_h}) begin
            failures++;
            $display("FAIL dual_release t=%0t got=%h exp=%h", $time, {short_press, long_press, repeat_press, key_held}, {e_s, e_l, e_r, e_h});
         end
         if (short_press == 4'b1001) n_pair++;
         if (short_press != 4'b0000) n_any++;
      end
      checks++;
      if (n_pair != 1 || n_any != 1) begin
         failures++;
         $display("FAIL dual_summary got pair=%0d any=%0d exp 1 1", n_pair, n_any);
      end
   endtask

   task automatic test_reflag();
      int n_long = 0, long_at = -1, cyc = 0;
      key_value = 4'b1110; key_flag = 1'b1;
      for (int ms = 0; ms < 12; ms++) begin
         for (int c = 0; c < CYC_PER_MS; c++) begin
            @(negedge sys_clk); key_flag = 1'b0;
            checks++;
            if ({short_press, long_press, repeat_press, key_held} !== {e_s, e_l, e_r, e_h}) begin
               failures++;
               $display("FAIL reflag_hold t=%0t got=%h exp=%h", $time, {short_press, long_press, repeat_press, key_held}, {e_s, e_l, e_r, e_h});
            end
            if (long_press == 4'b0001) begin n_long++; long_at = cyc; end
            cyc++;
         end
         if (ms < 8) key_flag = 1'b1;
      end
      key_value = 4'b1111; key_flag = 1'b1;
      repeat (3) begin
         @(negedge sys_clk); key_flag = 1'b0;
      end
      checks++;
      if (n_long != 1 || long_at < 9 * CYC_PER_MS - 1 || long_at > 10 * CYC_PER_MS) begin
         failures++;
         $display("FAIL reflag_summary got long=%0d at=%0d exp 1 ~10ms", n_long, long_at);
      end
   endtask

   task automatic test_reset_mid();
      int n_rel = 0, n_short = 0;
      key_value = 4'b1101; key_flag = 1'b1;
      for (int c = 0; c < 11 * CYC_PER_MS; c++) begin
         @(negedge sys_clk); key_flag = 1'b0;
         checks++;
         if ({short_press, long_press, repeat_press, key_held} !== {e_s, e_l, e_r, e_h}) begin
            failures++;
            $display("FAIL rstmid_hold t=%0t got=%h exp=%h", $time, {short_press, long_press, repeat_press, key_held}, {e_s, e_l, e_r, e_h});
         end
      end
      #2 sys_rst_n = 1'b0;
      #1;
      checks++;
      if ({short_press, long_press, repeat_press, key_held} !== 16'h0000) begin
         failures++;
         $display("FAIL rstmid_async got=%h exp=0000", {short_press, long_press, repeat_press, key_held});
      end
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      for (int c = 0; c < 500; c++) begin
         @(negedge sys_clk);
         checks++;
         if ({short_press, long_press, repeat_press, key_held} !== 16'h0000) begin
            failures++;
            $display("FAIL rstmid_idle t=%0t got=%h exp=0000", $time, {short_press, long_press, repeat_press, key_held});
         end
      end
      key_value = 4'b1111; key_flag = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge sys_clk); key_flag = 1'b0;
         checks++;
         if ({short_press, long_press, repeat_press, key_held} !== {e_s, e_l, e_r, e_h}) begin
            failures++;
            $display("FAIL rstmid_release t=%0t got=%h exp=%h", $time, {short_press, long_press, repeat_press, key_held}, {e_s, e_l, e_r, e_h});
         end
         if ((short_press | long_press | repeat_press | key_held) != 4'b0000) n_rel++;
      end
      key_value = 4'b1101; key_flag = 1'b1;
      for (int c = 0; c < 2 * CYC_PER_MS; c++) begin
         @(negedge sys_clk); key_flag = 1'b0;
         checks++;
         if ({short_press, long_press, repeat_press, key_held} !== {e_s, e_l, e_r, e_h}) begin
            failures++;
            $display("FAIL rstmid_repress t=%0t got=%h exp=%h", $time, {short_press, long_press, repeat_press, key_held}, {e_s, e_l, e_r, e_h});
         end
      end
      key_value = 4'b1111; key_flag = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge sys_clk); key_flag = 1'b0;
         if (short_press == 4'b0010) n_short++;
      end
      checks++;
      if (n_rel != 0 || n_short != 1) begin
         failures++;
         $display("FAIL rstmid_summary got stale=%0d short=%0d exp 0 1", n_rel, n_short);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 6 * CYC_PER_MS; c++) begin
         @(negedge sys_clk);
         if ($urandom_range(0, 299) == 0) begin
            key_flag  = 1'b1;
            key_value = 4'($urandom);
         end else begin
            key_flag  = 1'b0;
            key_value = 4'($urandom);
         end
         checks++;
         if ({short_press, long_press, repeat_press, key_held} !== {e_s, e_l, e_r, e_h}) begin
            failures++;
            $display("FAIL random t=%0t got=%h exp=%h", $time, {short_press, long_press, repeat_press, key_held}, {e_s, e_l, e_r, e_h});
         end
      end
      @(negedge sys_clk);
      key_value = 4'b1111; key_flag = 1'b1;
      @(negedge sys_clk); key_flag = 1'b0;
      @(negedge sys_clk);
      checks++;
      if ({short_press, long_press, repeat_press, key_held} !== {e_s, e_l, e_r, e_h} || key_held !== 4'b0000) begin
         failures++;
         $display("FAIL random_final got=%h exp=%h held=0", {short_press, long_press, repeat_press, key_held}, {e_s, e_l, e_r, e_h});
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog t=%0t exp=finish_before_limit", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      @(negedge sys_clk);
      test_short();
      test_long();
      test_coincide();
      test_dual();
      test_reflag();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
